// File: rtl/m68k_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_bus_master
//  Purpose  : Synchronous initiator for the 68000-style asynchronous bus.
//             Accepts one request at a time, runs a full AS/UDS/LDS/RW/FC
//             cycle, waits for synchronized DTACKn/BERRn and returns read
//             data or an error on a one-cycle response pulse.
//  Options  : BUS_MASTER_TIMEOUT_EN - when defined, a WAIT-state counter
//             raises a self-generated bus error after TIMEOUT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module m68k_bus_master #(
    parameter int TIMEOUT_CYCLES = 128,
    parameter int TO_W           = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    // client request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_rw,
    input  logic        req_siz,
    input  logic [2:0]  req_fc,
    // client response
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_berr,
    // 68000-style bus
    output logic [23:0] A,
    output logic [2:0]  FC,
    output logic        RW,
    output logic        ASn,
    output logic        UDSn,
    output logic        LDSn,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    input  logic        DTACKn,
    input  logic        BERRn
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_AERR   = 3'd1;  // address error: one quiet cycle before the response
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_ASRT   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_LATCH  = 3'd5;
    localparam logic [2:0] S_NEGATE = 3'd6;
    localparam logic [2:0] S_TERM   = 3'd7;

    logic [2:0]  state_q,     state_d;
    logic        dtack_s1_q,  dtack_s1_d;
    logic        dtack_s2_q,  dtack_s2_d;
    logic        berr_s1_q,   berr_s1_d;
    logic        berr_s2_q,   berr_s2_d;
    logic        rw_req_q,    rw_req_d;     // captured direction, survives RW release in TERM
    logic        siz_q,       siz_d;
    logic [23:0] a_q,         a_d;
    logic [2:0]  fc_q,        fc_d;
    logic        rw_bus_q,    rw_bus_d;
    logic        as_n_q,      as_n_d;
    logic        uds_n_q,     uds_n_d;
    logic        lds_n_q,     lds_n_d;
    logic [15:0] d_out_q,     d_out_d;
    logic        d_oe_q,      d_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_berr_q,  rsp_berr_d;

    // Data strobe lane selection: even byte -> upper lane, odd byte -> lower lane.
    logic uds_sel;
    logic lds_sel;
    assign uds_sel = siz_q | ~a_q[0];
    assign lds_sel = siz_q |  a_q[0];

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // WAIT-state timeout counter.
    always_ff @(posedge CLK) begin
        if (!RESETn) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    localparam int unused_timeout_cfg = TIMEOUT_CYCLES + TO_W;
`endif

    // Next-state and registered-output computation for the bus cycle sequencer.
    always_comb begin
        state_d     = state_q;
        dtack_s1_d  = DTACKn;
        dtack_s2_d  = dtack_s1_q;
        berr_s1_d   = BERRn;
        berr_s2_d   = berr_s1_q;
        rw_req_d    = rw_req_q;
        siz_d       = siz_q;
        a_d         = a_q;
        fc_d        = fc_q;
        rw_bus_d    = rw_bus_q;
        as_n_d      = as_n_q;
        uds_n_d     = uds_n_q;
        lds_n_d     = lds_n_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 16'h0000;
        rsp_berr_d  = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rw_req_d = req_rw;
                    siz_d    = req_siz;
                    if (req_siz && req_addr[0]) begin
                        state_d = S_AERR;
                    end else begin
                        state_d  = S_ADDR;
                        a_d      = req_addr;
                        fc_d     = req_fc;
                        rw_bus_d = req_rw;
                        d_oe_d   = ~req_rw;
                        d_out_d  = req_siz ? req_wdata : {req_wdata[7:0], req_wdata[7:0]};
                    end
                end
            end
            S_AERR: begin
                state_d     = S_NEGATE;
                rsp_valid_d = 1'b1;
                rsp_berr_d  = 1'b1;
            end
            S_ADDR: begin
                state_d = S_ASRT;
                as_n_d  = 1'b0;
                if (rw_req_q) begin
                    uds_n_d = ~uds_sel;
                    lds_n_d = ~lds_sel;
                end
            end
            S_ASRT: begin
                state_d = S_WAIT;
                if (!rw_req_q) begin
                    uds_n_d = ~uds_sel;
                    lds_n_d = ~lds_sel;
                end
`ifdef BUS_MASTER_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (!berr_s2_q) begin
                    state_d     = S_NEGATE;
                    as_n_d      = 1'b1;
                    uds_n_d     = 1'b1;
                    lds_n_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_berr_d  = 1'b1;
                end else if (!dtack_s2_q) begin
                    state_d = S_LATCH;
`ifdef BUS_MASTER_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = S_NEGATE;
                    as_n_d      = 1'b1;
                    uds_n_d     = 1'b1;
                    lds_n_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_berr_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            S_LATCH: begin
                state_d     = S_NEGATE;
                as_n_d      = 1'b1;
                uds_n_d     = 1'b1;
                lds_n_d     = 1'b1;
                rsp_valid_d = 1'b1;
                if (rw_req_q) begin
                    if (siz_q)       rsp_rdata_d = D_IN;
                    else if (a_q[0]) rsp_rdata_d = {8'h00, D_IN[7:0]};
                    else             rsp_rdata_d = {8'h00, D_IN[15:8]};
                end
            end
            S_NEGATE: begin
                state_d  = S_TERM;
                d_oe_d   = 1'b0;
                rw_bus_d = 1'b1;
            end
            S_TERM: begin
                if (dtack_s2_q && berr_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, synchronizer and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            dtack_s1_q  <= 1'b1;
            dtack_s2_q  <= 1'b1;
            berr_s1_q   <= 1'b1;
            berr_s2_q   <= 1'b1;
            rw_req_q    <= 1'b1;
            siz_q       <= 1'b0;
            a_q         <= 24'h000000;
            fc_q        <= 3'd0;
            rw_bus_q    <= 1'b1;
            as_n_q      <= 1'b1;
            uds_n_q     <= 1'b1;
            lds_n_q     <= 1'b1;
            d_out_q     <= 16'h0000;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_berr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dtack_s1_q  <= dtack_s1_d;
            dtack_s2_q  <= dtack_s2_d;
            berr_s1_q   <= berr_s1_d;
            berr_s2_q   <= berr_s2_d;
            rw_req_q    <= rw_req_d;
            siz_q       <= siz_d;
            a_q         <= a_d;
            fc_q        <= fc_d;
            rw_bus_q    <= rw_bus_d;
            as_n_q      <= as_n_d;
            uds_n_q     <= uds_n_d;
            lds_n_q     <= lds_n_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_berr_q  <= rsp_berr_d;
        end
    end

    assign req_ready = RESETn && (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_berr  = rsp_berr_q;
    assign A         = a_q;
    assign FC        = fc_q;
    assign RW        = rw_bus_q;
    assign ASn       = as_n_q;
    assign UDSn      = uds_n_q;
    assign LDSn      = lds_n_q;
    assign D_OUT     = d_out_q;
    assign D_OE      = d_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m68k_bus_master
//  Purpose  : Directed bench for m68k_bus_master with a simple bus responder
//             and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_master;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_rw;
    logic        req_siz;
    logic [2:0]  req_fc;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_berr;
    logic [23:0] A;
    logic [2:0]  FC;
    logic        RW;
    logic        ASn;
    logic        UDSn;
    logic        LDSn;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic [15:0] D_IN;
    logic        DTACKn;
    logic        BERRn;

    m68k_bus_master #(.TIMEOUT_CYCLES(16), .TO_W(8)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .req_siz(req_siz), .req_fc(req_fc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_berr(rsp_berr),
        .A(A), .FC(FC), .RW(RW), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
        .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .DTACKn(DTACKn), .BERRn(BERRn)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        berr;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Responder: DTACKn follows ASn after dt_wait cycles; berr_mode terminates with both.
    int dt_wait   = 0;
    bit berr_mode = 1'b0;
    bit silent    = 1'b0;
    int as_cnt    = 0;

    always @(posedge CLK) as_cnt <= ASn ? 0 : as_cnt + 1;

    always_comb begin
        DTACKn = 1'b1;
        BERRn  = 1'b1;
        if (!silent) begin
            if (berr_mode) begin
                DTACKn = ASn;
                BERRn  = ASn;
            end else begin
                DTACKn = ASn | (as_cnt < dt_wait);
            end
        end
    end

    // Bus values observed on the last cycle with ASn asserted.
    logic        m_uds, m_lds, m_rw, m_oe;
    logic [15:0] m_dout;
    logic [23:0] m_a;
    logic [2:0]  m_fc;
    bit          m_strobe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [23:0] addr, input logic [15:0] wd, input logic rw,
                           input logic siz, input logic [2:0] fc,
                           input logic [15:0] e_rd, input logic e_berr, input int e_lat);
        exp_t e;
        bit   got;
        e.rdata = e_rd;
        e.berr  = e_berr;
        e.lat   = e_lat;
        sb.push_back(e);
        m_strobe = 1'b0;
        got      = 1'b0;
        @(negedge CLK);
        req_addr  = addr;
        req_wdata = wd;
        req_rw    = rw;
        req_siz   = siz;
        req_fc    = fc;
        req_valid = 1'b1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 64 && !got; c++) begin
            @(posedge CLK);
            #1;
            if (!ASn) begin
                m_uds  = UDSn;
                m_lds  = LDSn;
                m_rw   = RW;
                m_oe   = D_OE;
                m_dout = D_OUT;
                m_a    = A;
                m_fc   = FC;
            end
            if (!ASn || !UDSn || !LDSn) m_strobe = 1'b1;
            if (rsp_valid) begin
                got = 1'b1;
                e   = sb.pop_front();
                check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                check("rsp_berr", {31'd0, rsp_berr}, {31'd0, e.berr});
                check("rsp_latency", c, e.lat);
            end
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
        if (!got) void'(sb.pop_front());
        @(posedge CLK);
        #1;
        check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        check("term_d_oe", {31'd0, D_OE}, 32'd0);
        check("term_rw", {31'd0, RW}, 32'd1);
        for (int c = 0; c < 20 && !req_ready; c++) begin
            @(posedge CLK);
            #1;
        end
        check("ready_return", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        RESETn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 24'h0;
        req_wdata = 16'h0;
        req_rw    = 1'b1;
        req_siz   = 1'b1;
        req_fc    = 3'd0;
        D_IN      = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h7);
        check("rst_rw_oe", {30'd0, RW, D_OE}, 32'h2);
        check("rst_a_fc", {5'd0, A, FC}, 32'h0);
        check("rst_dout", {16'd0, D_OUT}, 32'h0);
        check("rst_rsp", {14'd0, rsp_valid, rsp_berr, rsp_rdata}, 32'h0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        // Word read, immediate DTACK.
        D_IN = 16'hBEEF;
        run_req(24'h0E0000, 16'h0000, 1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0, 5);
        check("wr_strobes", {30'd0, m_uds, m_lds}, 32'h0);
        check("wr_rw", {31'd0, m_rw}, 32'd1);
        check("wr_a", {8'd0, m_a}, 32'h0E0000);
        check("wr_fc", {29'd0, m_fc}, 32'd5);

        // Byte write to an odd address.
        run_req(24'h000001, 16'h005A, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 5);
        check("bw_strobes", {30'd0, m_uds, m_lds}, 32'h2);
        check("bw_rw", {31'd0, m_rw}, 32'd0);
        check("bw_dout", {16'd0, m_dout}, 32'h5A5A);
        check("bw_oe", {31'd0, m_oe}, 32'd1);

        // Byte reads on each lane.
        D_IN = 16'h1234;
        run_req(24'h000100, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0012, 1'b0, 5);
        check("br_even_strobes", {30'd0, m_uds, m_lds}, 32'h1);
        run_req(24'h000101, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0034, 1'b0, 5);
        check("br_odd_strobes", {30'd0, m_uds, m_lds}, 32'h2);

        // Word write.
        run_req(24'h000200, 16'hA55A, 1'b0, 1'b1, 3'd6, 16'h0000, 1'b0, 5);
        check("ww_strobes", {30'd0, m_uds, m_lds}, 32'h0);
        check("ww_dout", {16'd0, m_dout}, 32'hA55A);

        // DTACK delayed by 10 cycles adds 10 cycles of latency.
        dt_wait = 10;
        D_IN    = 16'hCAFE;
        run_req(24'h0E0002, 16'h0000, 1'b1, 1'b1, 3'd5, 16'hCAFE, 1'b0, 15);
        dt_wait = 0;

        // BERR and DTACK together: error wins, data forced to zero.
        berr_mode = 1'b1;
        D_IN      = 16'hFFFF;
        run_req(24'h0E0004, 16'h0000, 1'b1, 1'b1, 3'd5, 16'h0000, 1'b1, 4);
        berr_mode = 1'b0;

        // Misaligned word: address error, no strobe ever asserts.
        run_req(24'h000003, 16'h0000, 1'b1, 1'b1, 3'd5, 16'h0000, 1'b1, 1);
        check("aerr_no_strobe", {31'd0, m_strobe}, 32'd0);

`ifdef BUS_MASTER_TIMEOUT_EN
        // No responder: self-generated bus error after 16 WAIT cycles.
        silent = 1'b1;
        run_req(24'h0E0006, 16'h0000, 1'b1, 1'b1, 3'd5, 16'h0000, 1'b1, 18);
        silent = 1'b0;
`endif

        // Reset during WAIT aborts the cycle with no response.
        silent = 1'b1;
        @(negedge CLK);
        req_addr  = 24'h0E0008;
        req_rw    = 1'b1;
        req_siz   = 1'b1;
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("abort_as_low", {31'd0, ASn}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_as_high", {29'd0, ASn, UDSn, LDSn}, 32'h7);
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("abort_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        silent = 1'b0;
        seen   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_silent", {31'd0, seen}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);

        // One more read to confirm normal operation after the abort.
        D_IN = 16'h0F0F;
        run_req(24'h00FFFE, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0F0F, 1'b0, 5);

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
